// File: rtl/iq_deserializer.sv
`timescale 1ns/1ps
// Serial I/Q framer + sign extension into a show-ahead FIFO for the packetizer.
// Word is readable one edge after the last frame bit is sampled; when the FIFO is full a push is dropped unless a pop happens on the same edge.

module iq_deser_fifo #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_dat,
    input  logic          i_pop,
    output logic [DW-1:0] o_dat,
    output logic          o_full,
    output logic          o_empty
);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_wr_en;
    logic          w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_en = i_pop && !o_empty;
    // A pop on the same edge frees the slot being written, so full does not block it.
    assign w_wr_en = i_push && (!o_full || w_rd_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
    end

    assign o_dat = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
endmodule

module iq_deserializer #(
    parameter int FIFO_AW     = 4,
    parameter int SAMPLE_BITS = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ser_data,
    input  logic        ser_valid,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_dr,
    output logic        locked,
    output logic [15:0] sync_err_cnt,
    output logic [15:0] drop_cnt
);
    typedef enum logic {S_HUNT, S_LOCKED} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    // Only the last 31 bits are kept; the incoming bit completes the 32-bit window.
    logic [30:0] r_sr;
    logic [31:0] w_sr_nxt;
    logic [4:0]  r_bit_cnt;
    logic [4:0]  w_bit_cnt_nxt;
    logic        w_sync_ok;
    logic        w_push;
    logic        w_sync_fail;
    logic [31:0] w_word;
    logic        r_push_vld;
    logic [31:0] r_push_dat;
    logic [15:0] r_sync_err_cnt;
    logic [15:0] r_drop_cnt;
    logic        w_full;
    logic        w_empty;
    logic        w_drop;

    assign w_sr_nxt  = {r_sr, ser_data};
    assign w_sync_ok = (w_sr_nxt[31:30] == 2'b10) && (w_sr_nxt[15:14] == 2'b01);
    assign w_word    = {{(16-SAMPLE_BITS){w_sr_nxt[29]}}, w_sr_nxt[29 -: SAMPLE_BITS],
                        {(16-SAMPLE_BITS){w_sr_nxt[13]}}, w_sr_nxt[13 -: SAMPLE_BITS]};

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_push        = 1'b0;
        w_sync_fail   = 1'b0;
        if (ser_valid) begin
            case (r_state)
                S_HUNT: begin
                    if (w_sync_ok) begin
                        w_push        = 1'b1;
                        w_state_nxt   = S_LOCKED;
                        w_bit_cnt_nxt = 5'd0;
                    end
                end
                S_LOCKED: begin
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd31) begin
                        if (w_sync_ok) begin
                            w_push = 1'b1;
                        end else begin
                            w_sync_fail   = 1'b1;
                            w_state_nxt   = S_HUNT;
                            w_bit_cnt_nxt = 5'd0;
                        end
                    end
                end
                default: w_state_nxt = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_HUNT;
            r_sr           <= '0;
            r_bit_cnt      <= '0;
            r_push_vld     <= 1'b0;
            r_push_dat     <= '0;
            r_sync_err_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_push_vld <= w_push;
            if (ser_valid) r_sr       <= w_sr_nxt[30:0];
            if (w_push)    r_push_dat <= w_word;
            if (w_sync_fail && (r_sync_err_cnt != 16'hFFFF))
                r_sync_err_cnt <= r_sync_err_cnt + 16'd1;
        end
    end

    assign w_drop = r_push_vld && w_full && !(rd_en && !w_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    iq_deser_fifo #(
        .DW (32),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_push_vld),
        .i_dat   (r_push_dat),
        .i_pop   (rd_en),
        .o_dat   (rd_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rd_dr        = !w_empty;
    assign locked       = (r_state == S_LOCKED);
    assign sync_err_cnt = r_sync_err_cnt;
    assign drop_cnt     = r_drop_cnt;
endmodule

// File: tb/tb_iq_deserializer.sv
`timescale 1ns/1ps
// Directed bench for iq_deserializer with a 4-deep FIFO; inputs change 1ns after the rising edge.

module tb_iq_deserializer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ser_data = 1'b0;
    logic        ser_valid = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_dr;
    logic        locked;
    logic [15:0] sync_err_cnt;
    logic [15:0] drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic        mon_en = 1'b0;
    logic [31:0] mon_q[$];

    iq_deserializer #(
        .FIFO_AW     (2),
        .SAMPLE_BITS (13)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ser_data     (ser_data),
        .ser_valid    (ser_valid),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_dr        (rd_dr),
        .locked       (locked),
        .sync_err_cnt (sync_err_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    // Records every word the consumer takes while rd_en is tied high.
    always @(negedge clk) begin
        if (mon_en && rd_en && rd_dr) mon_q.push_back(rd_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_frame(input logic [1:0] s, input logic [12:0] i,
                                             input logic [12:0] q);
        return {s, i, 1'b0, 2'b01, q, 1'b0};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        ser_data  = b;
        ser_valid = 1'b1;
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] f, input int gap);
        for (int i = 31; i >= 0; i--) begin
            send_bit(f[i]);
            if (gap > 0 && (i % 8) == 4) idle(gap);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk({tag, "_dr"}, {31'd0, rd_dr}, 32'd1);
        chk(tag, rd_data, exp);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    logic [31:0] f;
    logic [31:0] t4_exp [4] = '{32'h0001F001, 32'h0002F002, 32'h0003F003, 32'h0004F004};
    logic [31:0] t3_exp [4] = '{32'h0201F101, 32'h0202F102, 32'h0203F103, 32'h0204F104};
    logic [31:0] t5_exp [3] = '{32'h0FFF0001, 32'hF0000FFF, 32'h0555FAAA};
    logic [31:0] t5b_exp [4] = '{32'h03020042, 32'h03030043, 32'h03040044, 32'h03050045};
    logic [6:0]  prefix = 7'b1100110;

    initial begin
        // Reset state
        do_reset();
        chk("rst_dr",     {31'd0, rd_dr}, 32'd0);
        chk("rst_data",   rd_data, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_serr",   {16'd0, sync_err_cnt}, 32'd0);
        chk("rst_drop",   {16'd0, drop_cnt}, 32'd0);

        // T1: basic framing and latency
        send_frame(mk_frame(2'b10, 13'h0FFF, 13'h1000), 0);
        chk("t1_locked",  {31'd0, locked}, 32'd1);
        chk("t1_dr_N",    {31'd0, rd_dr}, 32'd0);
        idle(1);
        chk("t1_dr_N1",   {31'd0, rd_dr}, 32'd1);
        chk("t1_first",   rd_data, 32'h0FFFF000);
        send_frame(mk_frame(2'b10, 13'h0001, 13'h1FFF), 0);
        send_frame(mk_frame(2'b10, 13'h1555, 13'h0AAA), 0);
        idle(1);
        pop_chk("t1_w0", 32'h0FFFF000);
        pop_chk("t1_w1", 32'h0001FFFF);
        pop_chk("t1_w2", 32'hF5550AAA);
        chk("t1_empty",   {31'd0, rd_dr}, 32'd0);
        chk("t1_empty_d", rd_data, 32'd0);

        // T2: misaligned start
        do_reset();
        for (int i = 6; i >= 0; i--) send_bit(prefix[i]);
        f = mk_frame(2'b10, 13'h0000, 13'h0000);
        for (int i = 31; i >= 1; i--) send_bit(f[i]);
        idle(1);
        chk("t2_nolock",  {31'd0, locked}, 32'd0);
        chk("t2_nopush",  {31'd0, rd_dr}, 32'd0);
        send_bit(f[0]);
        chk("t2_locked",  {31'd0, locked}, 32'd1);
        send_frame(mk_frame(2'b10, 13'h0123, 13'h1F00), 0);
        idle(1);
        pop_chk("t2_w0", 32'h00000000);
        pop_chk("t2_w1", 32'h0123FF00);
        chk("t2_empty",   {31'd0, rd_dr}, 32'd0);
        chk("t2_serr",    {16'd0, sync_err_cnt}, 32'd0);

        // T4: overflow drops into a 4-deep FIFO
        do_reset();
        for (int k = 1; k <= 6; k++)
            send_frame(mk_frame(2'b10, 13'(k), 13'(32'h1000 + k)), 0);
        idle(1);
        chk("t4_drop", {16'd0, drop_cnt}, 32'd2);
        for (int k = 0; k < 4; k++) pop_chk($sformatf("t4_w%0d", k), t4_exp[k]);
        chk("t4_empty", {31'd0, rd_dr}, 32'd0);

        // T3: sync failure in frame 5 and relock (continues locked from T4)
        for (int k = 1; k <= 4; k++)
            send_frame(mk_frame(2'b10, 13'(32'h0200 + k), 13'(32'h1100 + k)), 0);
        idle(1);
        for (int k = 0; k < 4; k++) pop_chk($sformatf("t3_w%0d", k), t3_exp[k]);
        send_frame(mk_frame(2'b11, 13'h0000, 13'h0000), 0);
        chk("t3_unlock", {31'd0, locked}, 32'd0);
        chk("t3_serr",   {16'd0, sync_err_cnt}, 32'd1);
        idle(1);
        chk("t3_nopush", {31'd0, rd_dr}, 32'd0);
        send_frame(mk_frame(2'b10, 13'h00AB, 13'h00CD), 0);
        chk("t3_relock", {31'd0, locked}, 32'd1);
        send_frame(mk_frame(2'b10, 13'h1ABC, 13'h0123), 0);
        idle(1);
        pop_chk("t3_f6", 32'h00AB00CD);
        pop_chk("t3_f7", 32'hFABC0123);
        chk("t3_empty", {31'd0, rd_dr}, 32'd0);
        chk("t3_drop",  {16'd0, drop_cnt}, 32'd2);

        // T6: reset mid-frame with words buffered and counters non-zero
        for (int k = 1; k <= 3; k++)
            send_frame(mk_frame(2'b10, 13'(k), 13'(k)), 0);
        f = mk_frame(2'b10, 13'h1FFF, 13'h1FFF);
        for (int i = 31; i >= 22; i--) send_bit(f[i]);
        chk("t6_pre_dr", {31'd0, rd_dr}, 32'd1);
        do_reset();
        chk("t6_dr",     {31'd0, rd_dr}, 32'd0);
        chk("t6_data",   rd_data, 32'd0);
        chk("t6_locked", {31'd0, locked}, 32'd0);
        chk("t6_serr",   {16'd0, sync_err_cnt}, 32'd0);
        chk("t6_drop",   {16'd0, drop_cnt}, 32'd0);
        send_frame(mk_frame(2'b10, 13'h0777, 13'h1888), 0);
        idle(1);
        pop_chk("t6_first", 32'h0777F888);
        chk("t6_empty", {31'd0, rd_dr}, 32'd0);

        // T5: rd_en tied high, gapped serial input
        do_reset();
        mon_q.delete();
        mon_en = 1'b1;
        rd_en  = 1'b1;
        send_frame(mk_frame(2'b10, 13'h0FFF, 13'h0001), 3);
        idle(2);
        send_frame(mk_frame(2'b10, 13'h1000, 13'h0FFF), 2);
        send_frame(mk_frame(2'b10, 13'h0555, 13'h1AAA), 1);
        idle(4);
        mon_en = 1'b0;
        rd_en  = 1'b0;
        chk("t5_npops", mon_q.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("t5_w%0d", i), (i < mon_q.size()) ? mon_q[i] : 32'hDEADBEEF, t5_exp[i]);
        chk("t5_empty", {31'd0, rd_dr}, 32'd0);

        // T5b: push and pop on the same edge while full
        for (int k = 1; k <= 4; k++)
            send_frame(mk_frame(2'b10, 13'(32'h0300 + k), 13'(32'h0040 + k)), 0);
        idle(1);
        chk("t5b_full_head", rd_data, 32'h03010041);
        send_frame(mk_frame(2'b10, 13'h0305, 13'h0045), 0);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk("t5b_drop", {16'd0, drop_cnt}, 32'd0);
        for (int k = 0; k < 4; k++) pop_chk($sformatf("t5b_w%0d", k), t5b_exp[k]);
        chk("t5b_empty", {31'd0, rd_dr}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
